// File: rtl/pea_pkg.sv
// Shared types and defaults for the PE-array sequencer.
package pea_pkg;

    localparam int unsigned ROW_DEF    = 3;
    localparam int unsigned COL_DEF    = 8;
    localparam int unsigned PE_LAT_DEF = 2;
    localparam int unsigned KERNEL     = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLoadWgt,
        StStream,
        StDrain
    } pea_ctrl_state_e;

endpackage

// File: rtl/pea_ctrl_tagline.sv
// Fixed-latency tag delay line. Shifts every cycle, so a stall upstream
// becomes a bubble here. Bit 0 of each entry is the valid tag; empty_o
// reports that nothing is left in flight.
module pea_ctrl_tagline #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] tail_o,
    output logic             empty_o
);

    logic [Depth-1:0][Width-1:0] line_q, line_d;

    // Next-state: new entry at the head, everything else moves one step.
    always_comb begin
        line_d    = line_q;
        line_d[0] = in_i;
        for (int i = 1; i < Depth; i++) begin
            line_d[i] = line_q[i-1];
        end
    end

    // Line register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign tail_o  = line_q[Depth-1];
    assign empty_o = (line_q == '0);

endmodule

// File: rtl/pea_ctrl.sv
// Loop sequencer for the PE array: output channel x input channel x input
// row. Drives weight loads, per-column ifm shifts, psum-valid strobes and
// channel-done markers. Optional perf counters under PEA_CTRL_PERF_EN.
module pea_ctrl
    import pea_pkg::*;
#(
    parameter int unsigned COL    = COL_DEF,
    parameter int unsigned ROW    = ROW_DEF,
    parameter int unsigned PE_LAT = PE_LAT_DEF,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned H_W    = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     cfg_stride_i,
    input  logic [H_W-1:0]           cfg_h_i,
    input  logic [$clog2(COL+1)-1:0] cfg_cols_i,
    input  logic [CNT_W-1:0]         cfg_ic_num_i,
    input  logic [CNT_W-1:0]         cfg_oc_num_i,
    input  logic                     wgt_vld_i,
    input  logic                     ifm_vld_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     cfg_err_o,
    output logic                     stride_o,
    output logic                     wgt_read_o,
    output logic [COL-1:0]           ifm_read_o,
    output logic [COL-1:0]           pvalid_o,
    output logic                     ic_done_o,
    output logic                     oc_done_o,
    output logic [31:0]              perf_busy_cyc_o,
    output logic [31:0]              perf_stall_cyc_o
);

    localparam int unsigned CW = $clog2(COL + 1);
    localparam int unsigned DW = $clog2(PE_LAT + 1);

    pea_ctrl_state_e state_q, state_d;
    logic             stride_q, stride_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [CW-1:0]    cols_q, cols_d;
    logic [CNT_W-1:0] ic_num_q, ic_num_d;
    logic [CNT_W-1:0] oc_num_q, oc_num_d;
    logic [1:0]       wgt_cnt_q, wgt_cnt_d;
    logic [H_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] ic_cnt_q, ic_cnt_d;
    logic [CNT_W-1:0] oc_cnt_q, oc_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_bad;
    logic [COL-1:0]   col_mask;
    logic [H_W-1:0]   last_out_row;
    logic [2:0]       tag_in, tag_tail;
    logic             tag_empty;

    assign cfg_bad = (cfg_h_i < H_W'(ROW)) || (cfg_cols_i == '0) ||
                     (cfg_cols_i > CW'(COL)) || (cfg_ic_num_i == '0) ||
                     (cfg_oc_num_i == '0);

    // Thermometer mask of the active columns.
    always_comb begin
        col_mask = '0;
        for (int i = 0; i < COL; i++) begin
            col_mask[i] = (CW'(i) < cols_q);
        end
    end

    // Output-row tag for the row being accepted. Stride 2 with an even height
    // leaves the final row without an output, so the last output row is h-2.
    always_comb begin
        last_out_row = (stride_q && !h_q[0]) ? h_q - H_W'(2) : h_q - H_W'(1);
        tag_in       = '0;
        if (state_q == StStream && ifm_vld_i && row_cnt_q >= H_W'(ROW - 1) &&
            (!stride_q || !row_cnt_q[0])) begin
            tag_in[0] = 1'b1;
            tag_in[1] = (row_cnt_q == last_out_row) && (ic_cnt_q == ic_num_q - CNT_W'(1));
            tag_in[2] = tag_in[1] && (oc_cnt_q == oc_num_q - CNT_W'(1));
        end
    end

    pea_ctrl_tagline #(
        .Depth (PE_LAT),
        .Width (3)
    ) u_tagline (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_i    (tag_in),
        .tail_o  (tag_tail),
        .empty_o (tag_empty)
    );

    // Next-state logic, read enables and the done pulse.
    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        h_d         = h_q;
        cols_d      = cols_q;
        ic_num_d    = ic_num_q;
        oc_num_d    = oc_num_q;
        wgt_cnt_d   = wgt_cnt_q;
        row_cnt_d   = row_cnt_q;
        ic_cnt_d    = ic_cnt_q;
        oc_cnt_d    = oc_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cfg_err_d   = 1'b0;
        wgt_read_o  = 1'b0;
        ifm_read_o  = '0;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        stride_d  = cfg_stride_i;
                        h_d       = cfg_h_i;
                        cols_d    = cfg_cols_i;
                        ic_num_d  = cfg_ic_num_i;
                        oc_num_d  = cfg_oc_num_i;
                        wgt_cnt_d = '0;
                        row_cnt_d = '0;
                        ic_cnt_d  = '0;
                        oc_cnt_d  = '0;
                        state_d   = StLoadWgt;
                    end
                end
            end
            StLoadWgt: begin
                wgt_read_o = wgt_vld_i;
                if (wgt_vld_i) begin
                    if (wgt_cnt_q == 2'(KERNEL - 1)) begin
                        wgt_cnt_d = '0;
                        row_cnt_d = '0;
                        state_d   = StStream;
                    end else begin
                        wgt_cnt_d = wgt_cnt_q + 2'd1;
                    end
                end
            end
            StStream: begin
                ifm_read_o = {COL{ifm_vld_i}} & col_mask;
                if (ifm_vld_i) begin
                    if (row_cnt_q == h_q - H_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = StDrain;
                    end else begin
                        row_cnt_d = row_cnt_q + H_W'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_cnt_q < DW'(PE_LAT)) begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
                // Stay at least PE_LAT cycles and until every tag has left.
                if (tag_empty && drain_cnt_q >= DW'(PE_LAT - 1)) begin
                    state_d = StLoadWgt;
                    if (ic_cnt_q == ic_num_q - CNT_W'(1)) begin
                        ic_cnt_d = '0;
                        if (oc_cnt_q == oc_num_q - CNT_W'(1)) begin
                            oc_cnt_d = '0;
                            done_o   = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            oc_cnt_d = oc_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        ic_cnt_d = ic_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and loop-counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            stride_q    <= 1'b0;
            h_q         <= '0;
            cols_q      <= '0;
            ic_num_q    <= '0;
            oc_num_q    <= '0;
            wgt_cnt_q   <= '0;
            row_cnt_q   <= '0;
            ic_cnt_q    <= '0;
            oc_cnt_q    <= '0;
            drain_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            h_q         <= h_d;
            cols_q      <= cols_d;
            ic_num_q    <= ic_num_d;
            oc_num_q    <= oc_num_d;
            wgt_cnt_q   <= wgt_cnt_d;
            row_cnt_q   <= row_cnt_d;
            ic_cnt_q    <= ic_cnt_d;
            oc_cnt_q    <= oc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign cfg_err_o = cfg_err_q;
    assign stride_o  = stride_q;
    assign pvalid_o  = {COL{tag_tail[0]}} & col_mask;
    assign ic_done_o = tag_tail[1];
    assign oc_done_o = tag_tail[2];

`ifdef PEA_CTRL_PERF_EN
    logic [31:0] busy_cyc_q, busy_cyc_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic        stall;

    // Saturating perf counters, cleared when a job is accepted.
    always_comb begin
        stall = (state_q == StLoadWgt && !wgt_vld_i) || (state_q == StStream && !ifm_vld_i);
        busy_cyc_d  = busy_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (state_q == StIdle && start_i && !cfg_bad) begin
            busy_cyc_d  = '0;
            stall_cyc_d = '0;
        end else begin
            if (busy_o && busy_cyc_q != '1) busy_cyc_d = busy_cyc_q + 32'd1;
            if (stall && stall_cyc_q != '1) stall_cyc_d = stall_cyc_q + 32'd1;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            busy_cyc_q  <= busy_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign perf_busy_cyc_o  = busy_cyc_q;
    assign perf_stall_cyc_o = stall_cyc_q;
`else
    assign perf_busy_cyc_o  = '0;
    assign perf_stall_cyc_o = '0;
`endif

endmodule

// File: tb/tb_pea_ctrl.sv
// Bench for pea_ctrl: a transaction-level model (queue of expected beats and
// scheduled psum strobes) checked every cycle, plus literal per-job totals.
module tb_pea_ctrl;

    localparam int COL    = 8;
    localparam int PE_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start, cfg_stride, wgt_vld, ifm_vld;
    logic [9:0]  cfg_h;
    logic [3:0]  cfg_cols;
    logic [15:0] cfg_ic, cfg_oc;
    logic        busy, done, cfg_err, stride, wgt_read, ic_done, oc_done;
    logic [7:0]  ifm_read, pvalid;
    logic [31:0] perf_busy, perf_stall;

    always #5 clk = ~clk;

    pea_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .cfg_stride_i     (cfg_stride),
        .cfg_h_i          (cfg_h),
        .cfg_cols_i       (cfg_cols),
        .cfg_ic_num_i     (cfg_ic),
        .cfg_oc_num_i     (cfg_oc),
        .wgt_vld_i        (wgt_vld),
        .ifm_vld_i        (ifm_vld),
        .busy_o           (busy),
        .done_o           (done),
        .cfg_err_o        (cfg_err),
        .stride_o         (stride),
        .wgt_read_o       (wgt_read),
        .ifm_read_o       (ifm_read),
        .pvalid_o         (pvalid),
        .ic_done_o        (ic_done),
        .oc_done_o        (oc_done),
        .perf_busy_cyc_o  (perf_busy),
        .perf_stall_cyc_o (perf_stall)
    );

    // kind: 0 weight beat, 1 input row, 2 drain
    typedef struct {
        int   kind;
        bit   prod;
        bit   icl;
        bit   ocl;
        bit   last;
    } beat_t;
    typedef struct {
        int t;
        bit icd;
        bit ocd;
    } pv_t;

    beat_t     q[$];
    pv_t       pvq[$];
    int        cyc = 0;
    int        total = 0;
    int        bad = 0;
    bit        m_stride;
    logic [7:0] m_mask;
    int        m_err_at, m_exit, m_last_pv;
    int        m_busy_cnt, m_stall_cnt;

    // observed totals for literal checks
    int n_wgt, n_rd, n_pv, n_icd, n_ocd, n_done, n_err, last_pv_cyc, done_cyc;
    logic [7:0] pv_last, rd_last;
    int s_wgt, s_rd, s_pv, s_icd, s_ocd, s_done, s_err;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pvq.delete();
        m_stride    = 1'b0;
        m_mask      = '0;
        m_err_at    = -1;
        m_exit      = -1;
        m_last_pv   = -100;
        m_busy_cnt  = 0;
        m_stall_cnt = 0;
    endtask

    task automatic build_job(input int h, input int ic, input int oc, input bit s);
        int step, last_out;
        beat_t b;
        step     = s ? 2 : 1;
        last_out = 2 + step * ((h - 3) / step);
        for (int o = 0; o < oc; o++) begin
            for (int i = 0; i < ic; i++) begin
                for (int w = 0; w < 3; w++) begin
                    b = '{kind: 0, prod: 0, icl: 0, ocl: 0, last: 0};
                    q.push_back(b);
                end
                for (int r = 0; r < h; r++) begin
                    b.kind = 1;
                    b.prod = (r >= 2) && (!s || ((r - 2) % 2 == 0));
                    b.icl  = (r == last_out) && (i == ic - 1);
                    b.ocl  = b.icl && (o == oc - 1);
                    b.last = 0;
                    q.push_back(b);
                end
                b = '{kind: 2, prod: 0, icl: 0, ocl: 0,
                      last: (o == oc - 1) && (i == ic - 1)};
                q.push_back(b);
            end
        end
    endtask

    // Check this cycle's outputs against the model, then advance the model to
    // what the coming clock edge accepts.
    task automatic check_and_step();
        bit         exp_w, exp_done, exp_icd, exp_ocd, was_idle, bad_cfg;
        logic [7:0] exp_rd, exp_pv;
        exp_w = 0; exp_done = 0; exp_icd = 0; exp_ocd = 0;
        exp_rd = '0; exp_pv = '0;
        if (q.size() > 0) begin
            if (q[0].kind == 0) exp_w = wgt_vld;
            if (q[0].kind == 1) exp_rd = ifm_vld ? m_mask : 8'h00;
            if (q[0].kind == 2) begin
                if (m_exit < 0)
                    m_exit = (cyc + PE_LAT - 1 > m_last_pv + 1) ? cyc + PE_LAT - 1 : m_last_pv + 1;
                exp_done = (cyc == m_exit) && q[0].last;
            end
        end
        if (pvq.size() > 0 && pvq[0].t == cyc) begin
            exp_pv  = m_mask;
            exp_icd = pvq[0].icd;
            exp_ocd = pvq[0].ocd;
        end
        check("busy", busy, q.size() != 0);
        check("wgt_read", wgt_read, exp_w);
        check("ifm_read", ifm_read, exp_rd);
        check("pvalid", pvalid, exp_pv);
        check("ic_done", ic_done, exp_icd);
        check("oc_done", oc_done, exp_ocd);
        check("done", done, exp_done);
        check("cfg_err", cfg_err, cyc == m_err_at);
        check("stride", stride, m_stride);
`ifdef PEA_CTRL_PERF_EN
        check("perf_busy", perf_busy, m_busy_cnt);
        check("perf_stall", perf_stall, m_stall_cnt);
`else
        check("perf_busy", perf_busy, 0);
        check("perf_stall", perf_stall, 0);
`endif
        if (exp_pv != 0) void'(pvq.pop_front());

        was_idle = (q.size() == 0);
        if (!was_idle) begin
            m_busy_cnt++;
            case (q[0].kind)
                0: if (wgt_vld) void'(q.pop_front()); else m_stall_cnt++;
                1: begin
                    if (ifm_vld) begin
                        if (q[0].prod) begin
                            pvq.push_back('{t: cyc + PE_LAT, icd: q[0].icl, ocd: q[0].ocl});
                            m_last_pv = cyc + PE_LAT;
                        end
                        void'(q.pop_front());
                    end else begin
                        m_stall_cnt++;
                    end
                end
                default: if (cyc == m_exit) begin
                    void'(q.pop_front());
                    m_exit = -1;
                end
            endcase
        end else if (start) begin
            bad_cfg = (cfg_h < 3) || (cfg_cols < 1) || (cfg_cols > COL) ||
                      (cfg_ic == 0) || (cfg_oc == 0);
            if (bad_cfg) begin
                m_err_at = cyc + 1;
            end else begin
                build_job(int'(cfg_h), int'(cfg_ic), int'(cfg_oc), cfg_stride);
                m_stride    = cfg_stride;
                m_mask      = 8'((9'd1 << cfg_cols) - 9'd1);
                m_busy_cnt  = 0;
                m_stall_cnt = 0;
            end
        end
    endtask

    // One clock: sample mid-cycle, then move to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            model_clear();
        end else begin
            check_and_step();
            n_wgt += int'(wgt_read);
            if (ifm_read != 0) begin n_rd++; rd_last = ifm_read; end
            if (pvalid != 0) begin n_pv++; pv_last = pvalid; last_pv_cyc = cyc; end
            n_icd  += int'(ic_done);
            n_ocd  += int'(oc_done);
            if (done) begin n_done++; done_cyc = cyc; end
            n_err  += int'(cfg_err);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic snap();
        s_wgt = n_wgt; s_rd = n_rd; s_pv = n_pv; s_icd = n_icd;
        s_ocd = n_ocd; s_done = n_done; s_err = n_err;
    endtask

    task automatic set_cfg(input int h, input int cols, input int ic, input int oc, input bit s);
        cfg_h = 10'(h); cfg_cols = 4'(cols); cfg_ic = 16'(ic); cfg_oc = 16'(oc); cfg_stride = s;
    endtask

    task automatic run_job(input int h, input int cols, input int ic, input int oc,
                           input bit s, input bit stall_en);
        int k;
        snap();
        set_cfg(h, cols, ic, oc, s);
        wgt_vld = 1; ifm_vld = 1; start = 1;
        tick();
        start = 0;
        k = 0;
        while (n_done == s_done && k < 4000) begin
            if (stall_en) begin
                wgt_vld = (k % 3) != 1;
                ifm_vld = (k % 5) != 2;
            end
            tick();
            k++;
        end
        check("job_completes", n_done - s_done, 1);
        wgt_vld = 1; ifm_vld = 1;
        tick();
        tick();
    endtask

    task automatic bad_start(input string nm, input int h, input int cols, input int ic,
                             input int oc);
        snap();
        set_cfg(h, cols, ic, oc, 1'b0);
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        check(nm, n_err - s_err, 1);
        check({nm, "_nojob"}, n_wgt - s_wgt, 0);
    endtask

    initial begin
        rst = 1; start = 0; wgt_vld = 0; ifm_vld = 0;
        set_cfg(5, 8, 1, 1, 0);
        n_wgt = 0; n_rd = 0; n_pv = 0; n_icd = 0; n_ocd = 0; n_done = 0; n_err = 0;
        last_pv_cyc = 0; done_cyc = 0; pv_last = '0; rd_last = '0;
        model_clear();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_pvalid", pvalid, 0);

        // Stride 1, full width, no stalls
        run_job(5, 8, 1, 1, 0, 0);
        check("t1_wgt", n_wgt - s_wgt, 3);
        check("t1_rows", n_rd - s_rd, 5);
        check("t1_rd_val", rd_last, 8'hFF);
        check("t1_pv", n_pv - s_pv, 3);
        check("t1_pv_val", pv_last, 8'hFF);
        check("t1_icd", n_icd - s_icd, 1);
        check("t1_ocd", n_ocd - s_ocd, 1);
        check("t1_done_lag", done_cyc - last_pv_cyc, 1);

        // Stride 2, odd and even heights
        run_job(7, 8, 1, 1, 1, 0);
        check("s2h7_pv", n_pv - s_pv, 3);
        run_job(6, 8, 1, 1, 1, 0);
        check("s2h6_pv", n_pv - s_pv, 2);
        check("s2h6_rows", n_rd - s_rd, 6);

        // Partial column mask
        run_job(4, 5, 1, 1, 0, 0);
        check("c5_rd_val", rd_last, 8'h1F);
        check("c5_pv_val", pv_last, 8'h1F);
        check("c5_pv", n_pv - s_pv, 2);

        // Multi-channel with stalls
        run_job(5, 8, 2, 2, 0, 1);
        check("mc_wgt", n_wgt - s_wgt, 12);
        check("mc_rows", n_rd - s_rd, 20);
        check("mc_pv", n_pv - s_pv, 12);
        check("mc_icd", n_icd - s_icd, 2);
        check("mc_ocd", n_ocd - s_ocd, 1);

        // Rejected starts
        bad_start("err_h2", 2, 8, 1, 1);
        bad_start("err_ic0", 5, 8, 0, 1);
        bad_start("err_oc0", 5, 8, 1, 0);
        bad_start("err_cols0", 5, 0, 1, 1);
        bad_start("err_cols9", 5, 9, 1, 1);

        // Reset in the middle of streaming, then a clean job
        snap();
        set_cfg(20, 8, 1, 1, 1);
        start = 1; wgt_vld = 1; ifm_vld = 1;
        tick();
        start = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        check("rst_no_done", n_done - s_done, 0);
        check("rst_stride", stride, 0);
        run_job(3, 8, 1, 1, 0, 0);
        check("post_rst_pv", n_pv - s_pv, 1);
        check("post_rst_wgt", n_wgt - s_wgt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
